// File: rtl/loop_data_replay_ctrl.sv
// loop_data_replay_ctrl
// Buffers the channel words of one pixel, then replays them in channel order
// LOOP_NUM times so downstream conv stages can reuse each pixel per filter loop.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   valid_in   data_in carries a channel word
//   data_in    channel word, channel order 0..CH-1
//   ready_in   word accepted this cycle when valid_in is high (combinational)
//   data_out   replayed channel word (registered)
//   valid_out  data_out valid this cycle
//   loop_idx   loop iteration of the current data_out
//   last_out   data_out is channel CH-1 of loop LOOP_NUM-1
//   busy       replay in progress or output still pending
module loop_data_replay_ctrl #(
  parameter int unsigned DATA_WIDTH           = 2,
  parameter int unsigned CHANNEL_NUM_IN_PIXEL = 2,
  parameter int unsigned POINTER_WIDTH_LOOP   = 7,
  parameter int unsigned LOOP_NUM             = 4,
  parameter int unsigned LOOP_WIDTH           = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [LOOP_WIDTH-1:0] loop_idx,
  output logic                  last_out,
  output logic                  busy
);

  // Buffer address width; a single-entry buffer still gets a 1-bit address.
  localparam int unsigned ADDR_W = (CHANNEL_NUM_IN_PIXEL > 1) ? $clog2(CHANNEL_NUM_IN_PIXEL) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [POINTER_WIDTH_LOOP-1:0] PTR_LAST  = POINTER_WIDTH_LOOP'(CHANNEL_NUM_IN_PIXEL - 1);
  localparam logic [POINTER_WIDTH_LOOP-1:0] PTR_ONE   = POINTER_WIDTH_LOOP'(1);
  localparam logic [LOOP_WIDTH-1:0]         LOOP_LAST = LOOP_WIDTH'(LOOP_NUM - 1);
  localparam logic [LOOP_WIDTH-1:0]         LOOP_ONE  = LOOP_WIDTH'(1);

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_REPLAY = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [POINTER_WIDTH_LOOP-1:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH_LOOP-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOOP_WIDTH-1:0]         loop_cnt_q, loop_cnt_d;
  logic [DATA_WIDTH-1:0]         buf_q [DEPTH];
  logic [DATA_WIDTH-1:0]         buf_d [DEPTH];
  logic [DATA_WIDTH-1:0]         data_out_q, data_out_d;
  logic                          valid_out_q, valid_out_d;
  logic [LOOP_WIDTH-1:0]         loop_idx_q, loop_idx_d;
  logic                          last_out_q, last_out_d;
  logic                          busy_q, busy_d;

  logic              accept_c;
  logic              fill_done_c;
  logic              rd_en_c;
  logic              rd_wrap_c;
  logic              final_rd_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [ADDR_W-1:0] rd_addr_c;

  // Handshake and sequencing decode
  assign ready_in    = (state_q == ST_FILL);
  assign accept_c    = valid_in & ready_in;
  assign fill_done_c = accept_c & (wr_ptr_q == PTR_LAST);
  assign rd_en_c     = (state_q == ST_REPLAY);
  assign rd_wrap_c   = rd_en_c & (rd_ptr_q == PTR_LAST);
  assign final_rd_c  = rd_wrap_c & (loop_cnt_q == LOOP_LAST);
  assign wr_addr_c   = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr_c   = rd_ptr_q[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:   if (fill_done_c) state_d = ST_REPLAY;
      ST_REPLAY: if (final_rd_c)  state_d = ST_FILL;
    endcase
  end

  // Pointer and loop counter updates
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    loop_cnt_d = loop_cnt_q;
    if (accept_c) begin
      wr_ptr_d = fill_done_c ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (fill_done_c) begin
      rd_ptr_d   = '0;
      loop_cnt_d = '0;
    end
    if (rd_en_c) begin
      if (rd_wrap_c) begin
        rd_ptr_d   = '0;
        loop_cnt_d = final_rd_c ? '0 : loop_cnt_q + LOOP_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Channel buffer write
  always_comb begin
    buf_d = buf_q;
    if (accept_c) begin
      buf_d[wr_addr_c] = data_in;
    end
  end

  // Output register next values; data and loop index hold while idle
  always_comb begin
    data_out_d  = data_out_q;
    loop_idx_d  = loop_idx_q;
    valid_out_d = rd_en_c;
    last_out_d  = final_rd_c;
    if (rd_en_c) begin
      data_out_d = buf_q[rd_addr_c];
      loop_idx_d = loop_cnt_q;
    end
    busy_d = (state_d == ST_REPLAY) | valid_out_d;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      loop_cnt_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      loop_idx_q  <= '0;
      last_out_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      loop_cnt_q  <= loop_cnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      loop_idx_q  <= loop_idx_d;
      last_out_q  <= last_out_d;
      busy_q      <= busy_d;
    end
  end

  // Buffer storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign loop_idx  = loop_idx_q;
  assign last_out  = last_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_loop_data_replay_ctrl.sv
// Testbench for loop_data_replay_ctrl: instance A (CH=4, LOOP_NUM=3) and
// instance B (CH=1, LOOP_NUM=1) checked every cycle against a schedule-based
// reference model derived from the accept/replay timing rules.
module tb_loop_data_replay_ctrl;

  localparam int unsigned DW   = 8;
  localparam int unsigned LW   = 8;
  localparam int unsigned PW   = 7;
  localparam int unsigned CH_A = 4;
  localparam int unsigned L_A  = 3;
  localparam int unsigned CH_B = 1;
  localparam int unsigned L_B  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          a_valid_in, b_valid_in;
  logic [DW-1:0] a_data_in, b_data_in;
  logic          a_ready_in, b_ready_in;
  logic [DW-1:0] a_data_out, b_data_out;
  logic          a_valid_out, b_valid_out;
  logic [LW-1:0] a_loop_idx, b_loop_idx;
  logic          a_last_out, b_last_out;
  logic          a_busy, b_busy;

  loop_data_replay_ctrl #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN_PIXEL(CH_A), .POINTER_WIDTH_LOOP(PW),
    .LOOP_NUM(L_A), .LOOP_WIDTH(LW)
  ) dut_a (
    .clk(clk), .reset(reset), .valid_in(a_valid_in), .data_in(a_data_in),
    .ready_in(a_ready_in), .data_out(a_data_out), .valid_out(a_valid_out),
    .loop_idx(a_loop_idx), .last_out(a_last_out), .busy(a_busy)
  );

  loop_data_replay_ctrl #(
    .DATA_WIDTH(DW), .CHANNEL_NUM_IN_PIXEL(CH_B), .POINTER_WIDTH_LOOP(PW),
    .LOOP_NUM(L_B), .LOOP_WIDTH(LW)
  ) dut_b (
    .clk(clk), .reset(reset), .valid_in(b_valid_in), .data_in(b_data_in),
    .ready_in(b_ready_in), .data_out(b_data_out), .valid_out(b_valid_out),
    .loop_idx(b_loop_idx), .last_out(b_last_out), .busy(b_busy)
  );

  int tests = 0;
  int fails = 0;
  int c     = 0;

  // Reference model: collected words per instance and a cycle-stamped output schedule
  int            ch_n [2];
  int            lp_n [2];
  int            ready_from [2];
  logic [DW-1:0] pix_a [$];
  logic [DW-1:0] pix_b [$];
  logic [DW-1:0] exp_d [int];
  logic [LW-1:0] exp_i [int];
  bit            exp_l [int];
  logic [DW-1:0] hold_d [2];
  logic [LW-1:0] hold_i [2];

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d cycle %0d observed=%0h expected=%0h", tag, i, c, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_d.delete();
    exp_i.delete();
    exp_l.delete();
    pix_a.delete();
    pix_b.delete();
    for (int i = 0; i < 2; i++) begin
      ready_from[i] = 0;
      hold_d[i]     = '0;
      hold_i[i]     = '0;
    end
  endtask

  task automatic check_inst(input int i);
    logic          o_r, o_v, o_l, o_b;
    logic [DW-1:0] o_d;
    logic [LW-1:0] o_i;
    int            key;
    bit            ev, el, er;
    if (i == 0) begin
      o_r = a_ready_in; o_v = a_valid_out; o_l = a_last_out; o_b = a_busy;
      o_d = a_data_out; o_i = a_loop_idx;
    end else begin
      o_r = b_ready_in; o_v = b_valid_out; o_l = b_last_out; o_b = b_busy;
      o_d = b_data_out; o_i = b_loop_idx;
    end
    key = 2 * c + i;
    ev  = exp_d.exists(key);
    el  = 1'b0;
    if (ev) begin
      hold_d[i] = exp_d[key];
      hold_i[i] = exp_i[key];
      el        = exp_l[key];
    end
    er = (c >= ready_from[i]);
    chk("ready_in",  i, 32'(o_r), 32'(er));
    chk("valid_out", i, 32'(o_v), 32'(ev));
    chk("data_out",  i, 32'(o_d), 32'(hold_d[i]));
    chk("loop_idx",  i, 32'(o_i), 32'(hold_i[i]));
    chk("last_out",  i, 32'(o_l), 32'(el));
    chk("busy",      i, 32'(o_b), 32'(!er || ev));
  endtask

  // Record an accept; a completed pixel schedules CH*LOOP_NUM outputs from T+2
  task automatic model_drive(input int i, input bit v, input logic [DW-1:0] d);
    int n;
    logic [DW-1:0] w;
    if (v && c >= ready_from[i]) begin
      if (i == 0) pix_a.push_back(d); else pix_b.push_back(d);
      n = (i == 0) ? pix_a.size() : pix_b.size();
      if (n == ch_n[i]) begin
        for (int k = 0; k < ch_n[i] * lp_n[i]; k++) begin
          w = (i == 0) ? pix_a[k % ch_n[i]] : pix_b[k % ch_n[i]];
          exp_d[2 * (c + 2 + k) + i] = w;
          exp_i[2 * (c + 2 + k) + i] = LW'(k / ch_n[i]);
          exp_l[2 * (c + 2 + k) + i] = (k == ch_n[i] * lp_n[i] - 1);
        end
        ready_from[i] = c + ch_n[i] * lp_n[i] + 1;
        if (i == 0) pix_a.delete(); else pix_b.delete();
      end
    end
  endtask

  // One clock cycle: check outputs, then drive A as given and B randomly
  task automatic cycle(input bit va, input logic [DW-1:0] da);
    bit            vb;
    logic [DW-1:0] db;
    @(posedge clk);
    #1;
    c++;
    check_inst(0);
    check_inst(1);
    vb = 1'($urandom_range(0, 1));
    db = DW'($urandom);
    model_drive(0, va, da);
    model_drive(1, vb, db);
    a_valid_in = va;
    a_data_in  = da;
    b_valid_in = vb;
    b_data_in  = db;
  endtask

  task automatic run(input int n, input bit va);
    for (int k = 0; k < n; k++) cycle(va, DW'($urandom));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    #2;
    reset      = 1'b0;
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    ch_n[0] = CH_A; lp_n[0] = L_A;
    ch_n[1] = CH_B; lp_n[1] = L_B;
    model_reset();
    reset      = 1'b0;
    a_valid_in = 1'b0;
    b_valid_in = 1'b0;
    a_data_in  = '0;
    b_data_in  = '0;
    #3;
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Single pixel on consecutive cycles
    run(4, 1'b1);
    run(14, 1'b0);

    // Gapped fill, then valid_in held high while replaying
    for (int k = 0; k < 7; k++) cycle((k % 2) == 0, DW'($urandom));
    run(12, 1'b1);
    run(4, 1'b0);

    // Two back-to-back pixels with valid_in held high
    run(20, 1'b1);
    run(16, 1'b0);

    // Reset after five replayed words, then a fresh pixel
    run(4, 1'b1);
    run(6, 1'b0);
    do_reset();
    run(4, 1'b1);
    run(14, 1'b0);

    // Partial pixel discarded by reset, then a full pixel
    run(2, 1'b1);
    do_reset();
    run(4, 1'b1);
    run(14, 1'b0);

    // Random traffic
    for (int k = 0; k < 60; k++) cycle(1'($urandom_range(0, 1)), DW'($urandom));
    run(20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
